// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_det_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned MASK_MAX  = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Returns a vector with the low `len` bits set.
  function automatic logic [MASK_MAX-1:0] len_mask(input int unsigned len);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern compare.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             shift,
  input  logic             clr_hist,
  input  logic             x,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic             match
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_new, mask;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W:0]   fill_inc;
  logic             full;

  assign hist_new = {hist_q[PAT_W-2:0], x};
  assign mask     = PAT_W'(len_mask(32'(len)));
  assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign full     = (fill_inc >= {1'b0, len});
  // Match is judged on the history as it will be after this bit shifts in.
  assign match    = shift && full && ((hist_new & mask) == (pat & mask));

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_hist) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_new;
      fill_d = full ? len : fill_inc[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: config, run FSM, hit counting.
// Define OVERLAP_EN to keep history across a match (overlapping detection).
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             x_valid,
  input  logic             x,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             done,
  output logic             cfg_err
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             len_ok, shift, clr_hist, match;

  assign len_ok  = (cfg_len != '0) && (int'(cfg_len) <= PAT_W);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk      (clk),
    .clr_n    (clr_n),
    .shift    (shift),
    .clr_hist (clr_hist),
    .x        (x),
    .pat      (pat_q),
    .len      (len_q),
    .match    (match)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    err_d    = 1'b0;
    shift    = 1'b0;
    clr_hist = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_we) begin
          if (len_ok) begin
            pat_d    = cfg_pat;
            len_d    = cfg_len;
            target_d = cfg_target;
          end else begin
            err_d = 1'b1;
          end
        end
        // A same-cycle write decides start: illegal write blocks it, legal one supplies len.
        if (start) begin
          if (cfg_we ? !len_ok : (len_q == '0)) begin
            err_d = 1'b1;
          end else begin
            state_d  = S_RUN;
            cnt_d    = '0;
            clr_hist = 1'b1;
          end
        end
      end
      S_RUN: begin
        err_d = cfg_we;
        if (abort) begin
          state_d = S_IDLE;
        end else if (x_valid) begin
          shift = 1'b1;
          if (match) begin
            hit_d = 1'b1;
            cnt_d = cnt_inc;
`ifdef OVERLAP_EN
            clr_hist = 1'b0;
`else
            clr_hist = 1'b1;
`endif
            if ((target_q != '0) && (cnt_inc == target_q)) begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign hit     = hit_q;
  assign hit_cnt = cnt_q;
  assign cfg_err = err_q;

endmodule
